fifo_sram_ctrl: RTL and testbench

Single-clock FIFO controller that owns the pointer logic for a FIFOsram instance.
- Accepts a valid/ready write stream and drives the sram's port A write (addr/wdata/write_en).
- Drives the sram's port B read address and presents its registered read data as a valid/ready output stream.
- Accounts for the RAM's one-cycle registered read latency and its write-to-read delay so the output never exposes stale words.
- Sits between a producer (e.g. UART/host byte stream) and the consumer of the buffered words.

---
 rtl/fifo_sram_ctrl.sv | 132 +++++++++++++
 tb/tb_fifo_sram_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sram_ctrl.sv
//----------------------------------------------------------------------------
// fifo_sram_ctrl
//
// Purpose:
//   Pointer and handshake controller for a single-clock FIFO whose storage is
//   an external dual-port RAM (FIFOsram). The write stream is fed straight into
//   RAM port A. RAM port B is addressed with the next read pointer, so its
//   registered read data always holds the word at the current head of the FIFO.
//   A third pointer (vis_ptr) trails the write pointer by one edge. Only entries
//   that the registered read port can already return are shown on the output.
//
// Parameters:
//   WIDTH       data word width (must match the attached FIFOsram)
//   DEPTH       number of entries, power of two, >= 2 (must match FIFOsram)
//   ADDR_WIDTH  RAM address width, derived from DEPTH
//
// Ports:
//   clk          single clock for all logic and both RAM ports
//   rst          asynchronous, active-high reset
//   in_data      write stream data
//   in_valid     write stream valid
//   in_ready     write stream ready (FIFO not full)
//   out_data     read stream data, taken directly from ram_rdata_b
//   out_valid    read stream valid
//   out_ready    read stream ready
//   ram_addr_a   FIFOsram addr_a (write address)
//   ram_wdata_a  FIFOsram wdata_a
//   ram_we_a     FIFOsram write_en_a
//   ram_addr_b   FIFOsram addr_b (read address)
//   ram_rdata_b  FIFOsram rdata_b (registered, one-cycle latency)
//
// Optional feature (macro FIFO_LEVEL_EN):
//   level        current occupancy, 0..DEPTH
//   almost_full  high when occupancy >= DEPTH-1
//   Both ports and their logic are absent when the macro is undefined.
//----------------------------------------------------------------------------
module fifo_sram_ctrl #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [WIDTH-1:0]      ram_wdata_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [WIDTH-1:0]      ram_rdata_b
`ifdef FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full
`endif
);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    localparam int                   PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] FULL_COUNT = PTR_WIDTH'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] vis_ptr;
    logic [PTR_WIDTH-1:0] used;
    logic [PTR_WIDTH-1:0] wr_ptr_next;
    logic [PTR_WIDTH-1:0] rd_ptr_next;
    logic                 full;
    logic                 push;
    logic                 pop;

    // Handshake decode. The occupancy is the modular pointer difference, so it
    // stays exact across every wrap. out_valid compares against vis_ptr, not
    // wr_ptr. A word written on the last edge has not yet reached the RAM's
    // read register, so it must not be shown yet.
    always_comb begin
        used        = wr_ptr - rd_ptr;
        full        = (used == FULL_COUNT);
        in_ready    = !full;
        push        = in_valid && !full;
        out_valid   = (vis_ptr != rd_ptr);
        pop         = out_valid && out_ready;
        wr_ptr_next = push ? (wr_ptr + PTR_ONE) : wr_ptr;
        rd_ptr_next = pop  ? (rd_ptr + PTR_ONE) : rd_ptr;
    end

    // RAM port drive. Port B is addressed with the read pointer as it will
    // be after this edge. The registered read data therefore always belongs
    // to the head entry, both while the consumer stalls and right after a pop.
    assign ram_we_a    = push;
    assign ram_addr_a  = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wdata_a = in_data;
    assign ram_addr_b  = rd_ptr_next[ADDR_WIDTH-1:0];
    assign out_data    = ram_rdata_b;

    // Pointer registers. vis_ptr samples the pre-increment write pointer.
    // An entry written at one edge is therefore counted visible one edge later.
    // That is the first cycle in which port B can return the entry.
    // Reset discards all contents. The RAM itself is left alone, and out_valid
    // stays low until fresh data has made it through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            vis_ptr <= '0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            vis_ptr <= wr_ptr;
        end
    end

`ifdef FIFO_LEVEL_EN
    // Occupancy reporting. This output includes entries that are written but
    // not yet visible, because they already consume a slot.
    assign level       = used;
    assign almost_full = (used >= (FULL_COUNT - PTR_ONE));
`endif

`ifndef SYNTHESIS
    // Structural invariants. Occupancy never exceeds DEPTH, and the visible
    // pointer is never more than one entry behind the writer.
    assert property (@(posedge clk) disable iff (rst) used <= FULL_COUNT);
    assert property (@(posedge clk) disable iff (rst) (wr_ptr - vis_ptr) <= PTR_ONE);
`endif

endmodule

// File: tb/tb_fifo_sram_ctrl.sv
//----------------------------------------------------------------------------
// tb_fifo_sram_ctrl
//
// Purpose:
//   Self-checking bench for fifo_sram_ctrl with DEPTH=4 and WIDTH=8, attached
//   to a behavioural dual-port RAM that has a registered read port.
//   It runs a directed vector table, several multi-cycle sequences (streaming
//   with wrap, full with a simultaneous pop, reset mid-stream, and occupancy
//   when FIFO_LEVEL_EN is defined), and a randomized phase. The randomized
//   phase is checked against a queue model. In that model each word becomes
//   visible one cycle after the edge that accepted it.
//----------------------------------------------------------------------------
module tb_fifo_sram_ctrl;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 4;
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic                  clk;
    logic                  rst;
    logic [WIDTH-1:0]      in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] ram_addr_a;
    logic [WIDTH-1:0]      ram_wdata_a;
    logic                  ram_we_a;
    logic [ADDR_WIDTH-1:0] ram_addr_b;
    logic [WIDTH-1:0]      ram_rdata_b;
`ifdef FIFO_LEVEL_EN
    logic [ADDR_WIDTH:0]   level;
    logic                  almost_full;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    fifo_sram_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ram_addr_a  (ram_addr_a),
        .ram_wdata_a (ram_wdata_a),
        .ram_we_a    (ram_we_a),
        .ram_addr_b  (ram_addr_b),
        .ram_rdata_b (ram_rdata_b)
`ifdef FIFO_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    // Clock generation, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFOsram. It has a synchronous write on port A and a
    // registered read on port B. When both ports hit the same address in a
    // cycle, the read returns the old contents.
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    always_ff @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
        ram_rdata_b <= mem[ram_addr_b];
    end

    // Reference model. It holds the queue of accepted words, each tagged with
    // the cycle number of the edge that accepted it.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               t;
    } entry_t;
    entry_t model_q[$];
    int     cycle_no = 0;

    function automatic logic model_ready();
        return model_q.size() < DEPTH;
    endfunction

    function automatic logic model_valid();
        if (model_q.size() == 0) return 1'b0;
        return cycle_no >= model_q[0].t + 1;
    endfunction

    // One comparison. It prints a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Drives one cycle of inputs from the low phase and advances the model
    // across the edge. It returns on the following falling edge.
    task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        logic m_push;
        logic m_pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        m_push    = iv && model_ready();
        m_pop     = ordy && model_valid();
        @(posedge clk);
        cycle_no++;
        if (m_pop) void'(model_q.pop_front());
        if (m_push) model_q.push_back('{data: d, t: cycle_no});
        @(negedge clk);
    endtask

    // Compares every stream output against the reference model.
    task automatic checkModel(input string tag);
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'(model_ready()));
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(model_valid()));
        if (model_valid())
            checkOutput({tag, " out_data"}, 32'(out_data), 32'(model_q[0].data));
`ifdef FIFO_LEVEL_EN
        checkOutput({tag, " level"}, 32'(level), 32'(model_q.size()));
        checkOutput({tag, " almost_full"}, 32'(almost_full), 32'(model_q.size() >= DEPTH - 1));
`endif
    endtask

    // Holds reset for two edges, then releases it on a falling edge.
    task automatic resetDut();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        cycle_no = 0;
    endtask

    // Directed vector: inputs for one cycle, then the expected outputs
    // after the edge.
    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             e_ir;
        logic             e_ov;
        logic [WIDTH-1:0] e_data;
    } vec_t;
    localparam int NUM_VEC = 13;
    vec_t vecs [NUM_VEC];

    // Watchdog, so that the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] drain_exp [4];

        // Single push with a stalled consumer, then a four-deep fill that
        // stalls, ignores extra input, and drains in order.
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA0};
        vecs[5]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA0};
        vecs[6]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA0};
        vecs[7]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA1};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset ram_we_a", 32'(ram_we_a), 32'd0);
        checkOutput("reset ram_addr_a", 32'(ram_addr_a), 32'd0);
        checkOutput("reset ram_addr_b", 32'(ram_addr_b), 32'd0);
`ifdef FIFO_LEVEL_EN
        checkOutput("reset level", 32'(level), 32'd0);
        checkOutput("reset almost_full", 32'(almost_full), 32'd0);
`endif
        resetDut();

        for (int i = 0; i < NUM_VEC; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].ordy);
            checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov)
                checkOutput($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].e_data));
        end

        // Sustained streaming of 20 words through the 4-entry buffer.
        for (int i = 0; i < 22; i++) begin
            applyStimulus(i < 20, 8'(i), 1'b1);
            checkOutput($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
            checkOutput($sformatf("stream%0d out_valid", i), 32'(out_valid),
                        32'(i >= 1 && i <= 20));
            if (i >= 1 && i <= 20)
                checkOutput($sformatf("stream%0d out_data", i), 32'(out_data), 32'(i - 1));
        end

        // Full FIFO with a pop and a push offered together. The push is
        // refused, and the next word is accepted one cycle later.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0);
        checkOutput("full in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 8'hC0, 1'b1);
        checkOutput("full pop in_ready", 32'(in_ready), 32'd1);
        checkOutput("full pop out_valid", 32'(out_valid), 32'd1);
        checkOutput("full pop out_data", 32'(out_data), 32'hB1);
        applyStimulus(1'b1, 8'hC1, 1'b0);
        checkOutput("refill in_ready", 32'(in_ready), 32'd0);
`ifdef FIFO_LEVEL_EN
        checkOutput("refill level", 32'(level), 32'd4);
`endif
        drain_exp = '{8'hB1, 8'hB2, 8'hB3, 8'hC1};
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("drain%0d out_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("drain%0d out_data", k), 32'(out_data), 32'(drain_exp[k]));
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("drained out_valid", 32'(out_valid), 32'd0);

        // Reset while three entries are held.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hD0 + 8'(i), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("held out_valid", 32'(out_valid), 32'd1);
        checkOutput("held out_data", 32'(out_data), 32'hD0);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        cycle_no = 0;
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("post-rst out_valid early", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("post-rst out_valid", 32'(out_valid), 32'd1);
        checkOutput("post-rst out_data", 32'(out_data), 32'h5A);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("post-rst empty", 32'(out_valid), 32'd0);

`ifdef FIFO_LEVEL_EN
        // The occupancy outputs track each push and clear on reset.
        resetDut();
        checkOutput("lvl0 level", 32'(level), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'hE0 + 8'(i), 1'b0);
            checkOutput($sformatf("lvl%0d level", i + 1), 32'(level), 32'(i + 1));
            checkOutput($sformatf("lvl%0d almost_full", i + 1), 32'(almost_full),
                        32'(i + 1 >= 3));
        end
        resetDut();
        checkOutput("lvl rst level", 32'(level), 32'd0);
        checkOutput("lvl rst almost_full", 32'(almost_full), 32'd0);
`endif

        // Randomized traffic. The first half is biased towards filling the
        // FIFO, and the second half towards draining it.
        resetDut();
        for (int i = 0; i < 400; i++) begin
            logic iv;
            logic ordy;
            if (i < 200) begin
                iv   = ($urandom_range(0, 3) != 0);
                ordy = ($urandom_range(0, 3) == 0);
            end else begin
                iv   = ($urandom_range(0, 3) == 0);
                ordy = ($urandom_range(0, 3) != 0);
            end
            applyStimulus(iv, 8'($urandom), ordy);
            checkModel($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
